// File: rtl/mem_pkg.sv
// Shared definitions for the memory request controller and the mem_mdl memory model.
package mem_pkg;

    localparam int P_MEM_DW     = 8;
    localparam int P_MEM_AW     = 5;
    localparam int P_RD_LAT_MAX = 15;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } mem_ctrl_state_t;

endpackage

// File: rtl/mem_req_ctrl.sv
// Turns a valid/ready read/write request into a one-cycle strobe toward mem_mdl and
// returns read data after a fixed latency on a valid/ready response channel.
module mem_req_ctrl #(
    parameter int P_MEM_DW = mem_pkg::P_MEM_DW,
    parameter int P_MEM_AW = mem_pkg::P_MEM_AW,
    parameter int P_RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_rw,
    input  logic [P_MEM_AW-1:0] req_addr,
    input  logic [P_MEM_DW-1:0] req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [P_MEM_DW-1:0] rsp_rdata,
    output logic                m_cs,
    output logic                m_rw,
    output logic [P_MEM_AW-1:0] m_addr,
    output logic [P_MEM_DW-1:0] m_wdata,
    input  logic [P_MEM_DW-1:0] m_rdata
);
    import mem_pkg::*;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(P_RD_LAT - 1);

    mem_ctrl_state_t     state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                m_cs_q, m_cs_d;
    logic                m_rw_q, m_rw_d;
    logic [P_MEM_AW-1:0] m_addr_q, m_addr_d;
    logic [P_MEM_DW-1:0] m_wdata_q, m_wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [P_MEM_DW-1:0] rsp_rdata_q, rsp_rdata_d;

    // The memory-side registers double as the request latch: they are loaded on
    // acceptance and cleared on every other cycle so the idle bus reads as zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        m_cs_d      = 1'b0;
        m_rw_d      = RW_WRITE;
        m_addr_d    = '0;
        m_wdata_d   = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d   = ACCESS;
                    m_cs_d    = 1'b1;
                    m_rw_d    = req_rw;
                    m_addr_d  = req_addr;
                    m_wdata_d = req_wdata;
                end
            end
            ACCESS: begin
                if (m_rw_q == RW_READ) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_rdata_d = m_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            m_cs_q      <= 1'b0;
            m_rw_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            m_cs_q      <= m_cs_d;
            m_rw_q      <= m_rw_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign m_cs      = m_cs_q;
    assign m_rw      = m_rw_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: two controllers (read latency 1 and 4), each driving its own memory model.
module tb_mem_req_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid [2];
    logic       req_ready [2];
    logic       req_rw    [2];
    logic [4:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [7:0] rsp_rdata [2];
    logic       m_cs      [2];
    logic       m_rw      [2];
    logic [4:0] m_addr    [2];
    logic [7:0] m_wdata   [2];
    logic [7:0] m_rdata   [2];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 4;
        logic [7:0] mem     [32];
        logic [7:0] rd_pipe [LAT];

        mem_req_ctrl #(.P_MEM_DW(8), .P_MEM_AW(5), .P_RD_LAT(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_rw(req_rw[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_rdata(rsp_rdata[g]),
            .m_cs(m_cs[g]), .m_rw(m_rw[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]),
            .m_rdata(m_rdata[g])
        );

        // Memory model: strobe sampled at edge E, read data capturable at edge E+LAT.
        always @(posedge clk) begin
            if (m_cs[g]) begin
                if (m_rw[g]) rd_pipe[0] <= mem[m_addr[g]];
                else         mem[m_addr[g]] <= m_wdata[g];
            end
            for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
        assign m_rdata[g] = rd_pipe[LAT-1];
    end

    typedef struct {
        int         g;
        logic       rw;
        logic [4:0] addr;
        logic [7:0] data;
        int         acc;
    } ent_t;

    ent_t       sq[$];
    ent_t       rq[$];
    logic [7:0] exp_mem [2][32];
    int         n_chk, n_err, cyc;
    logic       hs_flag [2];
    logic       rv_prev [2];
    logic       rst_edge;
    logic       rand_rdy;

    task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(int g);
        return (g == 0) ? 1 : 4;
    endfunction

    function automatic int find_s(int g);
        int r = -1;
        for (int i = 0; i < sq.size(); i++) if (r < 0 && sq[i].g == g) r = i;
        return r;
    endfunction

    function automatic int find_r(int g);
        int r = -1;
        for (int i = 0; i < rq.size(); i++) if (r < 0 && rq[i].g == g) r = i;
        return r;
    endfunction

    task automatic mon();
        int   i;
        ent_t e;
        for (int g = 0; g < 2; g++) begin
            if (rst_edge) begin
                check_val("rst_outputs", 32'({m_cs[g], m_rw[g], m_addr[g], m_wdata[g],
                                              rsp_valid[g], rsp_rdata[g]}), 32'd0);
                check_val("rst_ready", 32'(req_ready[g]), 32'd1);
            end
            if (m_cs[g]) begin
                i = find_s(g);
                if (i < 0) begin
                    check_val("strobe_extra", 32'd1, 32'd0);
                end else begin
                    e = sq[i];
                    sq.delete(i);
                    check_val("strobe_rw", 32'(m_rw[g]), 32'(e.rw));
                    check_val("strobe_addr", 32'(m_addr[g]), 32'(e.addr));
                    if (!e.rw) check_val("strobe_wdata", 32'(m_wdata[g]), 32'(e.data));
                    check_val("strobe_lat", 32'(cyc - e.acc), 32'd1);
                end
            end else begin
                check_val("idle_bus", 32'({m_addr[g], m_wdata[g]}), 32'd0);
            end
            if (rsp_valid[g]) begin
                i = find_r(g);
                if (i < 0) begin
                    check_val("rsp_extra", 32'd1, 32'd0);
                end else begin
                    if (!rv_prev[g]) check_val("rsp_lat", 32'(cyc - rq[i].acc), 32'(lat_of(g) + 2));
                    check_val("rsp_data", 32'(rsp_rdata[g]), 32'(rq[i].data));
                end
            end
            rv_prev[g] = rsp_valid[g];
        end
    endtask

    // Record handshakes taken at the coming posedge, then sample outputs at the negedge.
    task automatic step();
        int   i;
        ent_t e;
        rst_edge = rst;
        if (rst) begin
            sq.delete();
            rq.delete();
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (req_valid[g] && req_ready[g]) begin
                    hs_flag[g] = 1'b1;
                    e.g = g; e.rw = req_rw[g]; e.addr = req_addr[g];
                    e.data = req_wdata[g]; e.acc = cyc;
                    sq.push_back(e);
                    if (req_rw[g]) begin
                        e.data = exp_mem[g][req_addr[g]];
                        rq.push_back(e);
                    end else begin
                        exp_mem[g][req_addr[g]] = req_wdata[g];
                    end
                end
                if (rsp_valid[g] && rsp_ready[g]) begin
                    i = find_r(g);
                    if (i >= 0) rq.delete(i);
                end
            end
        end
        @(negedge clk);
        cyc++;
        mon();
        if (rand_rdy) rsp_ready[0] = 1'($urandom_range(0, 1));
    endtask

    task automatic do_req(int g, logic rw, logic [4:0] a, logic [7:0] d);
        req_valid[g] = 1'b1; req_rw[g] = rw; req_addr[g] = a; req_wdata[g] = d;
        hs_flag[g] = 1'b0;
        for (int n = 0; n < 50 && !hs_flag[g]; n++) step();
        if (!hs_flag[g]) check_val("req_timeout", 32'd0, 32'd1);
        req_valid[g] = 1'b0;
    endtask

    task automatic drain(int g);
        int n = 0;
        while (n < 60 && !(req_ready[g] && !rsp_valid[g] && find_r(g) < 0 && find_s(g) < 0)) begin
            step();
            n++;
        end
        if (n >= 60) check_val("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit [31:0]  written;
        logic [4:0] a;
        n_chk = 0; n_err = 0; cyc = 0;
        rst = 1'b1; rand_rdy = 1'b0; rst_edge = 1'b0; written = '0;
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 1'b0; req_rw[g] = 1'b0; req_addr[g] = '0; req_wdata[g] = '0;
            rsp_ready[g] = 1'b1; hs_flag[g] = 1'b0; rv_prev[g] = 1'b0;
        end

        // Reset and idle
        repeat (3) step();
        rst = 1'b0;
        repeat (2) step();
        check_val("ready_idle", 32'(req_ready[0]), 32'd1);

        // Single write, then read back (latency 1)
        do_req(0, 1'b0, 5'h07, 8'hab);
        drain(0);
        do_req(0, 1'b1, 5'h07, 8'h00);
        drain(0);

        // Response backpressure with a second request held by the source
        do_req(0, 1'b0, 5'h1f, 8'h5a);
        drain(0);
        rsp_ready[0] = 1'b0;
        do_req(0, 1'b1, 5'h1f, 8'h00);
        for (int n = 0; n < 20 && !rsp_valid[0]; n++) step();
        check_val("bp_rsp_seen", 32'(rsp_valid[0]), 32'd1);
        req_valid[0] = 1'b1; req_rw[0] = 1'b0; req_addr[0] = 5'h03; req_wdata[0] = 8'h11;
        hs_flag[0] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            check_val("bp_ready", 32'(req_ready[0]), 32'd0);
            check_val("bp_valid", 32'(rsp_valid[0]), 32'd1);
            check_val("bp_rdata", 32'(rsp_rdata[0]), 32'h5a);
            step();
        end
        check_val("bp_held", 32'(hs_flag[0]), 32'd0);
        rsp_ready[0] = 1'b1;
        for (int n = 0; n < 10 && !hs_flag[0]; n++) step();
        check_val("bp_accept", 32'(hs_flag[0]), 32'd1);
        req_valid[0] = 1'b0;
        drain(0);
        do_req(0, 1'b1, 5'h03, 8'h00);
        drain(0);

        // Latency 4 instance
        do_req(1, 1'b0, 5'h00, 8'h3c);
        drain(1);
        do_req(1, 1'b1, 5'h00, 8'h00);
        drain(1);

        // Reset while a latency-4 read sits in WAIT
        do_req(1, 1'b0, 5'h07, 8'hab);
        drain(1);
        do_req(1, 1'b1, 5'h07, 8'h00);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (8) step();
        check_val("rst_no_rsp", 32'(rsp_valid[1]), 32'd0);
        do_req(1, 1'b1, 5'h07, 8'h00);
        drain(1);

        // Mixed random traffic with random response backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = 5'($urandom_range(0, 31));
            if (!written[a] || $urandom_range(0, 1) == 0) begin
                written[a] = 1'b1;
                do_req(0, 1'b0, a, 8'($urandom_range(0, 255)));
            end else begin
                do_req(0, 1'b1, a, 8'h00);
            end
        end
        rand_rdy = 1'b0;
        rsp_ready[0] = 1'b1;
        drain(0);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Request-side controller sitting directly upstream of the mem_mdl memory model; it alone drives mem_mdl's m_cs/m_rw/m_addr/m_wdata and consumes m_rdata.
- Converts a valid/ready request channel (read or write) into a single-cycle memory access strobe.
- For reads, waits a fixed read latency, captures m_rdata and returns it on a valid/ready response channel.
- At most one transaction is outstanding.

Parameters:
- P_MEM_DW, 8, data width; must match mem_mdl.
- P_MEM_AW, 5, address width; must match mem_mdl.
- P_RD_LAT, 1, number of clk edges from the edge at which mem_mdl samples a read strobe to the edge at which m_rdata is valid for capture; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high, sampled on posedge clk.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_rw  in  1  1 = read, 0 = write (same encoding as m_rw).
- req_addr  in  P_MEM_AW  request address.
- req_wdata  in  P_MEM_DW  write data; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  P_MEM_DW  captured read data.
- m_cs  out  1  memory chip select (to mem_mdl).
- m_rw  out  1  memory read/write select.
- m_addr  out  P_MEM_AW  memory address.
- m_wdata  out  P_MEM_DW  memory write data.
- m_rdata  in  P_MEM_DW  memory read data.

Behaviour:
- Reset (rst=1 at a posedge):
  - State goes to IDLE.
  - m_cs, m_rw, m_addr, m_wdata, rsp_valid and rsp_rdata all become 0.
  - The latency counter clears.
  - req_ready becomes 1 from the following cycle.
- Reset mid-operation: any in-flight access or pending response is dropped, no response is ever issued for it, and m_cs is deasserted after the reset edge.
- Idle bus values: m_addr and m_wdata are driven to 0 whenever m_cs=0, never X.
- All memory-side outputs are registered.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready=1, combinational from state only.
  - On posedge with req_valid=1: latch rw/addr/wdata and go to ACCESS.
- ACCESS: for exactly one cycle, m_cs=1, m_rw=latched rw, m_addr/m_wdata=latched values. mem_mdl samples the strobe at the edge ending this cycle (edge E).
  - Write: go to IDLE at E. The write is complete and produces no response.
  - Read: go to WAIT at E and load the counter with P_RD_LAT-1.
- WAIT:
  - m_cs=0.
  - Decrement the counter each edge.
  - At edge E+P_RD_LAT (the edge where the counter reads 0), capture m_rdata into rsp_rdata, set rsp_valid=1 and go to RESP.
- RESP:
  - rsp_valid and rsp_rdata are held stable until rsp_ready=1 at a posedge.
  - On that edge, rsp_valid drops and the state goes to IDLE.
- req_ready=0 in ACCESS, WAIT and RESP. Requests arriving in those states are not accepted and must be held by the source.
- Throughput: one write per 2 cycles; one read per P_RD_LAT+3 cycles with rsp_ready tied to 1.
- Latency: write strobe appears 1 cycle after acceptance. Read data is visible P_RD_LAT+2 cycles after the acceptance edge.
- Full address range 0..2^P_MEM_AW-1 is legal; no address arithmetic and no wrap logic.
- Read-after-write to the same address returns the new data, because the write strobe always completes before the next acceptance.

Decomposition:
- Shared package mem_pkg holds:
  - P_MEM_DW/P_MEM_AW defaults, shared with mem_mdl.
  - Localparam RW_READ=1 / RW_WRITE=0.
  - State enum typedef mem_ctrl_state_t {IDLE, ACCESS, WAIT, RESP}.
  - P_RD_LAT_MAX=15.
- No sub-module. The FSM, the 4-bit latency counter and the request/response registers sit in one module.
- The bench instantiates mem_req_ctrl driving mem_mdl, using the same posedge-sampled monitor style.

Test Plan (clk period 20, P_RD_LAT=1 unless stated):
- Reset and idle:
  - Stimulus: rst high 3 cycles, req_valid=0.
  - Response: m_cs=0, m_addr=0, rsp_valid=0 throughout; req_ready=1 after the reset edge.
- Single write:
  - Stimulus: write addr 5'h07 data 8'hab.
  - Response: m_cs=1, m_rw=0, m_addr=7, m_wdata=ab for exactly one cycle starting 1 cycle after acceptance; no rsp_valid.
- Write then read back:
  - Stimulus: write 5'h07/8'hab, then read 5'h07 with rsp_ready=1.
  - Response: one read strobe cycle; rsp_valid pulses one cycle with rsp_rdata=ab, 3 cycles after the read acceptance edge.
- Response backpressure:
  - Stimulus: read 5'h1f (preloaded 8'h5a) with rsp_ready=0 for 6 cycles.
  - Response: rsp_valid=1 and rsp_rdata=5a held stable all 6 cycles; req_ready=0 while a second request is held; the second request is accepted only after rsp_ready=1.
- Latency parameter:
  - Stimulus: P_RD_LAT=4, read 5'h00 (preloaded 8'h3c).
  - Response: rsp_valid rises 6 cycles after acceptance with rsp_rdata=3c; m_cs high for exactly 1 cycle.
- Reset mid-read:
  - Stimulus: assert rst during the WAIT state (P_RD_LAT=4).
  - Response: rsp_valid never asserts for that read; all outputs are 0 after the reset edge; the next read of 5'h07 returns ab normally.
